// File: rtl/bpu_pkg.sv
// Shared definitions for the branch-prediction controller: counter and
// controller state encodings plus the PC field layout defaults.
package bpu_pkg;

   localparam int PC_XLEN       = 32;
   localparam int PC_INDEX_BITS = 6;
   localparam int IDX_LSB       = 2;

   typedef enum logic [1:0] {
      NTS = 2'b00,
      NTW = 2'b01,
      TW  = 2'b10,
      TS  = 2'b11
   } ctr_t;

   typedef enum logic {
      INIT = 1'b0,
      RUN  = 1'b1
   } state_t;

endpackage

// File: rtl/bpu_ctr_next.sv
// Next-state function of a 2-bit predictor counter given a resolved outcome.
module bpu_ctr_next
   import bpu_pkg::*;
(
   input  ctr_t ctr,
   input  logic taken,
   output ctr_t ctr_next
);

   // A weak not-taken entry jumps straight to strong taken on a taken outcome
   always_comb begin
      ctr_next = ctr;
      unique case (ctr)
         NTS:     ctr_next = taken ? NTW : NTS;
         NTW:     ctr_next = taken ? TS  : NTS;
         TW:      ctr_next = taken ? TS  : NTS;
         TS:      ctr_next = taken ? TS  : TW;
         default: ctr_next = NTS;
      endcase
   end

endmodule

// File: rtl/bpu_ctrl.sv
// Branch-prediction controller: direct-mapped counter/tag/target table,
// IF-stage prediction, EX-stage resolution, clear sweep and statistics.
module bpu_ctrl
   import bpu_pkg::*;
#(
   parameter int XLEN       = PC_XLEN,
   parameter int INDEX_BITS = PC_INDEX_BITS
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            tbl_clear,
   output logic            ready,
   input  logic [XLEN-1:0] if_pc,
   output logic            pred_taken,
   output logic [XLEN-1:0] pred_target,
   input  logic            ex_valid,
   input  logic            ex_is_branch,
   input  logic [XLEN-1:0] ex_pc,
   input  logic            ex_taken,
   input  logic [XLEN-1:0] ex_target,
   input  logic            ex_pred_taken,
   input  logic [XLEN-1:0] ex_pred_target,
   output logic            mispredict,
   output logic [XLEN-1:0] redirect_pc,
   output logic [31:0]     branch_cnt,
   output logic [31:0]     mispred_cnt
);

   localparam int ENTRIES  = 1 << INDEX_BITS;
   localparam int TAG_LSB  = INDEX_BITS + IDX_LSB;
   localparam int TAG_BITS = XLEN - TAG_LSB;

   logic                valid_q  [ENTRIES];
   logic [TAG_BITS-1:0] tag_q    [ENTRIES];
   ctr_t                ctr_q    [ENTRIES];
   logic [XLEN-1:0]     target_q [ENTRIES];

   state_t                state_q, state_d;
   logic [INDEX_BITS-1:0] sweep_q, sweep_d;

   logic [INDEX_BITS-1:0] if_idx, ex_idx;
   logic [TAG_BITS-1:0]   if_tag, ex_tag;
   logic [1:0]            if_ctr;
   logic                  if_hit, ex_hit;
   logic                  res, alias_hit, branch_mis;
   ctr_t                  ex_ctr_in, ex_ctr_next;

   assign if_idx = if_pc[TAG_LSB-1:IDX_LSB];
   assign if_tag = if_pc[XLEN-1:TAG_LSB];
   assign ex_idx = ex_pc[TAG_LSB-1:IDX_LSB];
   assign ex_tag = ex_pc[XLEN-1:TAG_LSB];

   assign ready = (state_q == RUN);

   // Prediction reads the registered table only, so a same-cycle update is not visible
   assign if_ctr      = ctr_q[if_idx];
   assign if_hit      = ready && valid_q[if_idx] && (tag_q[if_idx] == if_tag);
   assign pred_taken  = if_hit && if_ctr[1];
   assign pred_target = pred_taken ? target_q[if_idx] : if_pc + XLEN'(4);

   assign res        = ex_valid && ex_is_branch;
   assign alias_hit  = ex_valid && !ex_is_branch && ex_pred_taken;
   assign branch_mis = res && ((ex_taken != ex_pred_taken) ||
                               (ex_taken && (ex_pred_target != ex_target)));
   assign mispredict  = branch_mis || alias_hit;
   assign redirect_pc = (res && ex_taken) ? ex_target : ex_pc + XLEN'(4);

   assign ex_hit    = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
   assign ex_ctr_in = ex_hit ? ctr_q[ex_idx] : NTS;

   bpu_ctr_next u_ctr_next (
      .ctr      (ex_ctr_in),
      .taken    (ex_taken),
      .ctr_next (ex_ctr_next)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= INIT;
         sweep_q <= '0;
      end else begin
         state_q <= state_d;
         sweep_q <= sweep_d;
      end
   end

   always_comb begin
      state_d = state_q;
      sweep_d = sweep_q;
      if (tbl_clear) begin
         state_d = INIT;
         sweep_d = '0;
      end else if (state_q == INIT) begin
         if (sweep_q == '1) begin
            state_d = RUN;
            sweep_d = '0;
         end else begin
            sweep_d = sweep_q + 1'b1;
         end
      end
   end

   // Sweep writes one entry per cycle; EX updates only land in RUN with no clear pending
   always_ff @(posedge clk) begin
      if (state_q == INIT) begin
         valid_q[sweep_q] <= 1'b0;
         ctr_q[sweep_q]   <= NTS;
      end else if (!tbl_clear) begin
         if (res) begin
            valid_q[ex_idx]  <= 1'b1;
            tag_q[ex_idx]    <= ex_tag;
            ctr_q[ex_idx]    <= ex_ctr_next;
            target_q[ex_idx] <= ex_target;
         end else if (alias_hit) begin
            valid_q[ex_idx] <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         branch_cnt  <= '0;
         mispred_cnt <= '0;
      end else begin
         if (res && (branch_cnt != '1))
            branch_cnt <= branch_cnt + 32'd1;
         if (mispredict && (mispred_cnt != '1))
            mispred_cnt <= mispred_cnt + 32'd1;
      end
   end

endmodule

// File: tb/tb_bpu_ctrl.sv
// Self-checking bench for bpu_ctrl: directed vector table, clear/reset
// sequences and randomized traffic against a table-level reference model.
module tb_bpu_ctrl;

   typedef struct {
      logic [31:0] if_pc;
      logic        ex_valid;
      logic        ex_is_branch;
      logic [31:0] ex_pc;
      logic        ex_taken;
      logic [31:0] ex_target;
      logic        ex_pred_taken;
      logic [31:0] ex_pred_target;
      logic        tbl_clear;
   } stim_t;

   typedef struct {
      stim_t       s;
      logic        e_pt;
      logic [31:0] e_ptgt;
      logic        e_mis;
      logic [31:0] e_redir;
      int          e_br;
      int          e_mp;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        tbl_clear;
   logic        ready;
   logic [31:0] if_pc;
   logic        pred_taken;
   logic [31:0] pred_target;
   logic        ex_valid;
   logic        ex_is_branch;
   logic [31:0] ex_pc;
   logic        ex_taken;
   logic [31:0] ex_target;
   logic        ex_pred_taken;
   logic [31:0] ex_pred_target;
   logic        mispredict;
   logic [31:0] redirect_pc;
   logic [31:0] branch_cnt;
   logic [31:0] mispred_cnt;

   int checks = 0;
   int errors = 0;

   bit          m_valid [64];
   logic [23:0] m_tag   [64];
   int          m_ctr   [64];
   logic [31:0] m_tgt   [64];
   int          m_left;
   longint      m_br, m_mp;

   vec_t vecs [17];

   bpu_ctrl dut (
      .clk            (clk),
      .rst            (rst),
      .tbl_clear      (tbl_clear),
      .ready          (ready),
      .if_pc          (if_pc),
      .pred_taken     (pred_taken),
      .pred_target    (pred_target),
      .ex_valid       (ex_valid),
      .ex_is_branch   (ex_is_branch),
      .ex_pc          (ex_pc),
      .ex_taken       (ex_taken),
      .ex_target      (ex_target),
      .ex_pred_taken  (ex_pred_taken),
      .ex_pred_target (ex_pred_target),
      .mispredict     (mispredict),
      .redirect_pc    (redirect_pc),
      .branch_cnt     (branch_cnt),
      .mispred_cnt    (mispred_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("[TB] FAIL timeout actual=running required=finished");
      $fatal(1, "[TB] timeout");
   end

   function automatic stim_t mks(input logic [31:0] ipc, input logic v, input logic b,
                                 input logic [31:0] pc, input logic t, input logic [31:0] tgt,
                                 input logic pt, input logic [31:0] ptgt);
      stim_t s;
      s.if_pc = ipc; s.ex_valid = v; s.ex_is_branch = b; s.ex_pc = pc;
      s.ex_taken = t; s.ex_target = tgt; s.ex_pred_taken = pt;
      s.ex_pred_target = ptgt; s.tbl_clear = 1'b0;
      return s;
   endfunction

   function automatic stim_t idle(input logic [31:0] ipc, input logic [31:0] pc);
      return mks(ipc, 0, 0, pc, 0, 32'h0, 0, 32'h0);
   endfunction

   // Reference model: table indexed by word address modulo 64, tag is the rest
   function automatic int m_idx(input logic [31:0] pc);
      return int'((pc >> 2) % 64);
   endfunction

   function automatic logic [31:0] m_pred_target(input logic [31:0] pc);
      int i = m_idx(pc);
      if (m_left == 0 && m_valid[i] && m_tag[i] == pc[31:8] && m_ctr[i] >= 2)
         return m_tgt[i];
      return pc + 32'd4;
   endfunction

   function automatic logic m_pred_taken(input logic [31:0] pc);
      int i = m_idx(pc);
      return (m_left == 0 && m_valid[i] && m_tag[i] == pc[31:8] && m_ctr[i] >= 2);
   endfunction

   function automatic logic m_mis(input stim_t s);
      if (s.ex_valid && s.ex_is_branch)
         return (s.ex_taken != s.ex_pred_taken) ||
                (s.ex_taken && s.ex_pred_target != s.ex_target);
      return s.ex_valid && s.ex_pred_taken;
   endfunction

   function automatic logic [31:0] m_redir(input stim_t s);
      if (s.ex_valid && s.ex_is_branch && s.ex_taken) return s.ex_target;
      return s.ex_pc + 32'd4;
   endfunction

   task automatic modelReset();
      for (int i = 0; i < 64; i++) m_valid[i] = 0;
      m_left = 64;
      m_br = 0;
      m_mp = 0;
   endtask

   task automatic modelStep(input stim_t s);
      int  i = m_idx(s.ex_pc);
      bit  res = s.ex_valid && s.ex_is_branch;
      if (res && m_br < 64'hFFFF_FFFF) m_br++;
      if (m_mis(s) && m_mp < 64'hFFFF_FFFF) m_mp++;
      if (s.tbl_clear) begin
         for (int k = 0; k < 64; k++) m_valid[k] = 0;
         m_left = 64;
      end else if (m_left > 0) begin
         m_left--;
      end else if (res) begin
         if (m_valid[i] && m_tag[i] == s.ex_pc[31:8]) begin
            if (s.ex_taken) m_ctr[i] = (m_ctr[i] == 0) ? 1 : 3;
            else            m_ctr[i] = (m_ctr[i] == 3) ? 2 : 0;
         end else begin
            m_valid[i] = 1;
            m_tag[i]   = s.ex_pc[31:8];
            m_ctr[i]   = s.ex_taken ? 1 : 0;
         end
         m_tgt[i] = s.ex_target;
      end else if (s.ex_valid && s.ex_pred_taken) begin
         m_valid[i] = 0;
      end
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%h expected=%h", nm, act, exp);
      end
   endtask

   task automatic applyStimulus(input stim_t s);
      tbl_clear      = s.tbl_clear;
      if_pc          = s.if_pc;
      ex_valid       = s.ex_valid;
      ex_is_branch   = s.ex_is_branch;
      ex_pc          = s.ex_pc;
      ex_taken       = s.ex_taken;
      ex_target      = s.ex_target;
      ex_pred_taken  = s.ex_pred_taken;
      ex_pred_target = s.ex_pred_target;
      #1;
   endtask

   task automatic checkOutput(input string nm, input stim_t s);
      chk({nm, ".ready"},       ready,       (m_left == 0));
      chk({nm, ".pred_taken"},  pred_taken,  m_pred_taken(s.if_pc));
      chk({nm, ".pred_target"}, pred_target, m_pred_target(s.if_pc));
      chk({nm, ".mispredict"},  mispredict,  m_mis(s));
      chk({nm, ".redirect_pc"}, redirect_pc, m_redir(s));
      chk({nm, ".branch_cnt"},  branch_cnt,  m_br[31:0]);
      chk({nm, ".mispred_cnt"}, mispred_cnt, m_mp[31:0]);
   endtask

   task automatic advance(input stim_t s);
      @(posedge clk);
      modelStep(s);
      @(negedge clk);
   endtask

   task automatic runCycle(input string nm, input stim_t s);
      applyStimulus(s);
      checkOutput(nm, s);
      advance(s);
   endtask

   initial begin
      stim_t s;
      int    ready_wait;

      vecs[0]  = '{mks(32'h200, 1, 1, 32'h200, 1, 32'h180, 0, 32'h204), 0, 32'h204, 1, 32'h180, 0, 0};
      vecs[1]  = '{mks(32'h200, 1, 1, 32'h200, 1, 32'h180, 0, 32'h204), 0, 32'h204, 1, 32'h180, 1, 1};
      vecs[2]  = '{mks(32'h200, 1, 1, 32'h200, 1, 32'h180, 1, 32'h180), 1, 32'h180, 0, 32'h180, 2, 2};
      vecs[3]  = '{idle(32'h200, 32'h200),                              1, 32'h180, 0, 32'h204, 3, 2};
      vecs[4]  = '{mks(32'h200, 1, 1, 32'h200, 0, 32'h180, 1, 32'h180), 1, 32'h180, 1, 32'h204, 3, 2};
      vecs[5]  = '{idle(32'h200, 32'h200),                              1, 32'h180, 0, 32'h204, 4, 3};
      vecs[6]  = '{mks(32'h200, 1, 1, 32'h200, 0, 32'h180, 1, 32'h180), 1, 32'h180, 1, 32'h204, 4, 3};
      vecs[7]  = '{idle(32'h200, 32'h200),                              0, 32'h204, 0, 32'h204, 5, 4};
      vecs[8]  = '{mks(32'h200, 1, 1, 32'h300, 1, 32'h340, 0, 32'h304), 0, 32'h204, 1, 32'h340, 5, 4};
      vecs[9]  = '{mks(32'h300, 1, 1, 32'h300, 1, 32'h340, 0, 32'h304), 0, 32'h304, 1, 32'h340, 6, 5};
      vecs[10] = '{idle(32'h300, 32'h300),                              1, 32'h340, 0, 32'h304, 7, 6};
      vecs[11] = '{idle(32'h200, 32'h200),                              0, 32'h204, 0, 32'h204, 7, 6};
      vecs[12] = '{mks(32'h300, 1, 0, 32'h200, 0, 32'h0, 1, 32'h340),   1, 32'h340, 1, 32'h204, 7, 6};
      vecs[13] = '{idle(32'h300, 32'h300),                              0, 32'h304, 0, 32'h304, 7, 7};
      vecs[14] = '{mks(32'h300, 1, 1, 32'h300, 1, 32'h340, 0, 32'h304), 0, 32'h304, 1, 32'h340, 7, 7};
      vecs[15] = '{mks(32'h300, 1, 1, 32'h300, 1, 32'h340, 0, 32'h304), 0, 32'h304, 1, 32'h340, 8, 8};
      vecs[16] = '{idle(32'h300, 32'h300),                              1, 32'h340, 0, 32'h304, 9, 9};

      // Reset and the power-on sweep
      rst = 1'b1;
      applyStimulus(idle(32'h100, 32'h0));
      modelReset();
      repeat (2) @(negedge clk);
      chk("reset.ready", ready, 1'b0);
      chk("reset.branch_cnt", branch_cnt, 32'd0);
      chk("reset.mispred_cnt", mispred_cnt, 32'd0);
      rst = 1'b0;
      for (int i = 0; i < 64; i++) runCycle("sweep", idle(32'h100, 32'h0));
      applyStimulus(idle(32'h100, 32'h0));
      chk("sweep.ready_on_65", ready, 1'b1);
      chk("sweep.pred_target", pred_target, 32'h104);

      // Directed table
      for (int i = 0; i < 17; i++) begin
         applyStimulus(vecs[i].s);
         chk($sformatf("vec%0d.pred_taken", i),  pred_taken,  vecs[i].e_pt);
         chk($sformatf("vec%0d.pred_target", i), pred_target, vecs[i].e_ptgt);
         chk($sformatf("vec%0d.mispredict", i),  mispredict,  vecs[i].e_mis);
         chk($sformatf("vec%0d.redirect_pc", i), redirect_pc, vecs[i].e_redir);
         chk($sformatf("vec%0d.branch_cnt", i),  branch_cnt,  vecs[i].e_br);
         chk($sformatf("vec%0d.mispred_cnt", i), mispred_cnt, vecs[i].e_mp);
         checkOutput($sformatf("vec%0d.model", i), vecs[i].s);
         advance(vecs[i].s);
      end

      // Clear concurrent with an update: update dropped, sweep restarts
      s = mks(32'h300, 1, 1, 32'h300, 0, 32'h340, 1, 32'h340);
      s.tbl_clear = 1'b1;
      applyStimulus(s);
      chk("clear.mispredict", mispredict, 1'b1);
      chk("clear.redirect_pc", redirect_pc, 32'h304);
      checkOutput("clear", s);
      advance(s);
      ready_wait = 0;
      for (int i = 0; i < 64; i++) begin
         applyStimulus(idle(32'h300, 32'h300));
         if (ready !== 1'b1) ready_wait++;
         checkOutput("clear_sweep", idle(32'h300, 32'h300));
         advance(idle(32'h300, 32'h300));
      end
      chk("clear.low_cycles", ready_wait, 64);
      applyStimulus(idle(32'h300, 32'h300));
      chk("clear.ready", ready, 1'b1);
      chk("clear.pred_taken", pred_taken, 1'b0);
      chk("clear.pred_target", pred_target, 32'h304);
      chk("clear.branch_cnt", branch_cnt, 32'd10);
      chk("clear.mispred_cnt", mispred_cnt, 32'd10);

      // Randomized traffic from a small PC pool so entries hit and alias
      for (int n = 0; n < 1500; n++) begin
         logic [31:0] pool [6];
         pool[0] = 32'h200; pool[1] = 32'h300; pool[2] = 32'h204;
         pool[3] = 32'h1000; pool[4] = 32'h1200; pool[5] = $urandom & 32'hFFFF_FFFC;
         s.if_pc        = pool[$urandom_range(0, 5)];
         s.ex_pc        = pool[$urandom_range(0, 5)];
         s.ex_valid     = ($urandom_range(0, 9) < 8);
         s.ex_is_branch = ($urandom_range(0, 9) < 8);
         s.ex_taken     = $urandom_range(0, 1);
         s.ex_target    = pool[$urandom_range(0, 5)] + 32'h40;
         if ($urandom_range(0, 9) < 7) begin
            s.ex_pred_taken  = m_pred_taken(s.ex_pc);
            s.ex_pred_target = m_pred_target(s.ex_pc);
         end else begin
            s.ex_pred_taken  = $urandom_range(0, 1);
            s.ex_pred_target = $urandom;
         end
         s.tbl_clear = ($urandom_range(0, 299) == 0);
         runCycle("rand", s);
      end

      // Asynchronous reset in the middle of a sweep
      s = idle(32'h200, 32'h200);
      s.tbl_clear = 1'b1;
      runCycle("pre_rst_clear", s);
      for (int i = 0; i < 20; i++) runCycle("pre_rst_sweep", idle(32'h200, 32'h200));
      rst = 1'b1;
      #1;
      chk("async_rst.ready", ready, 1'b0);
      chk("async_rst.branch_cnt", branch_cnt, 32'd0);
      chk("async_rst.mispred_cnt", mispred_cnt, 32'd0);
      modelReset();
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 64; i++) runCycle("rst_sweep", idle(32'h100, 32'h0));
      applyStimulus(idle(32'h100, 32'h0));
      chk("rst_sweep.ready", ready, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/bpu_ctrl.md
Name: bpu_ctrl

Overview:
- Branch-prediction controller for the 5-stage RISC-V pipeline.
- Owns a direct-mapped table of 2-bit saturating predictor counters, each with a tag and a target.
- IF stage: serves a combinational prediction.
- EX stage: resolves the branch, detects misprediction, generates flush/redirect and sequences the counter and target update.
- Runs a table-clear sweep after reset and on request, and keeps branch and mispredict statistics.

Parameters:
- XLEN, 32, address width.
- INDEX_BITS, 6, table index width; the table has 2^INDEX_BITS entries.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous, active-high reset
- tbl_clear  input  1  request a full table-clear sweep
- ready  output  1  table valid, predictions enabled
- if_pc  input  XLEN  fetch PC
- pred_taken  output  1  predicted taken
- pred_target  output  XLEN  predicted next PC
- ex_valid  input  1  EX-stage instruction valid
- ex_is_branch  input  1  EX instruction is a conditional branch
- ex_pc  input  XLEN  EX instruction PC
- ex_taken  input  1  resolved outcome
- ex_target  input  XLEN  computed branch target, valid regardless of outcome
- ex_pred_taken  input  1  prediction carried down the pipe
- ex_pred_target  input  XLEN  predicted target carried down the pipe
- mispredict  output  1  flush IF/ID, redirect fetch
- redirect_pc  output  XLEN  correct next PC
- branch_cnt  output  32  resolved branches, saturating
- mispred_cnt  output  32  mispredictions, saturating

Behaviour:
- Address split:
  - idx = pc[INDEX_BITS+1:2]
  - tag = pc[XLEN-1:INDEX_BITS+2]
- Entry fields: valid, tag, ctr[1:0], target.
- Counter encoding: NTS=00, NTW=01, TW=10, TS=11. Next state on taken / not-taken:
  - NTS -> NTW / NTS
  - NTW -> TS / NTS
  - TW -> TS / NTS
  - TS -> TS / TW
- Controller FSM states: INIT and RUN.
  - rst asserted: state=INIT, sweep index=0, ready=0, branch_cnt=0, mispred_cnt=0.
  - INIT: clears valid[idx] and sets ctr[idx]=NTS, one entry per cycle. After the entry 2^INDEX_BITS-1 is cleared, the next state is RUN, with ready=1 in that following cycle.
  - tbl_clear sampled high in any state forces INIT with index 0 next cycle; it also restarts a sweep already in progress.
  - rst mid-sweep returns asynchronously to INIT at index 0.
- Prediction (combinational, zero latency):
  - hit = ready && valid[idx] && tag match.
  - pred_taken = hit && ctr[1].
  - pred_target = pred_taken ? target : if_pc+4.
  - While not ready: pred_taken=0 and pred_target=if_pc+4.
- Resolution (combinational):
  - res = ex_valid && ex_is_branch.
  - Branch mispredict = res && (ex_taken != ex_pred_taken || (ex_taken && ex_pred_target != ex_target)).
  - Non-branch with ex_valid && !ex_is_branch && ex_pred_taken (aliasing): mispredict=1.
  - redirect_pc = (res && ex_taken) ? ex_target : ex_pc+4.
  - mispredict is computed in all states, including INIT.
- Update (at posedge, RUN only; updates arriving in INIT are dropped):
  - res and the entry tag-matches ex_pc: ctr <= next(ctr, ex_taken); target <= ex_target.
  - res and miss: allocate valid=1, tag, ctr=next(NTS, ex_taken) (NTW if taken, else NTS), target=ex_target.
  - Aliased non-branch: clear valid at that idx.
- Simultaneous events:
  - IF read and EX write to the same idx in one cycle: the prediction returns the pre-update contents; there is no bypass.
  - tbl_clear concurrent with an update: the clear wins and the update is dropped.
- Statistics:
  - branch_cnt increments on res.
  - mispred_cnt increments on mispredict.
  - Both saturate at 32'hFFFF_FFFF and count in all states.
- Arithmetic: PC+4 wraps modulo 2^XLEN.

Decomposition:
- Shared package bpu_pkg holds:
  - counter encodings NTS/NTW/TW/TS;
  - controller state encodings INIT/RUN;
  - the idx/tag field-width localparams.
- One sub-module: bpu_ctr_next, a combinational next-state function implementing the counter transitions.
- The table array, sweep FSM and statistics stay in bpu_ctrl.

Test Plan:
- Reset, then hold tbl_clear=0 -> ready=0 for 64 cycles, ready=1 on cycle 65. During the sweep, if_pc=0x100 gives pred_taken=0 and pred_target=0x104.
- Branch at 0x200, target 0x180, resolved taken 3 times (each a predicted not-taken mispredict at first):
  - counter goes NTW, TS, TS;
  - fetch 0x200 then predicts taken, target 0x180;
  - mispred_cnt=2 and branch_cnt=3.
- From TS, resolve not-taken -> mispredict=1, redirect_pc=0x204, counter=TW, prediction still taken. Resolve not-taken again -> counter=NTS.
- Alias: 0x200 and 0x300 share idx 0 (INDEX_BITS=6). Resolve 0x300 taken -> entry reallocated with tag of 0x300. Fetch 0x200 -> hit=0, pred_taken=0.
- Non-branch at 0x200 with ex_pred_taken=1 -> mispredict=1, redirect_pc=0x204, entry invalidated.
- Assert tbl_clear mid-run, with an update in the same cycle -> update dropped, ready=0 for 64 cycles, all entries miss afterwards, statistics unchanged.
